ps2_key_decoder: RTL and testbench

//  PS/2 keyboard front end. Sits directly upstream of the game logic stage.

---
 rtl/ps2_key_decoder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end.
// The raw pins are synchronised and ps2_clk is filtered. The frame FSM then
// assembles and checks each byte. A make/break tracker turns mapped key
// events into ASCII on data, with a one-cycle display strobe.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       display,
   output logic       key_held,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Reset: asserts asynchronously and releases on a clock edge.
   // ------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic       w_rst;

   // Reset synchroniser: held high immediately on rst, released two edges later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rst_sync <= 2'b11;
      else     r_rst_sync <= {r_rst_sync[0], 1'b0};
   end

   assign w_rst = r_rst_sync[1];

   // ------------------------------------------------------------------
   // Pin synchronisers. The pins idle high (open-drain pull-ups), so the
   // flops reset high. That way reset release does not look like a fall.
   // ------------------------------------------------------------------
   logic [1:0] r_clk_sync;
   logic [1:0] r_dat_sync;
   logic       w_clk_s;
   logic       w_dat_s;

   // Two-flop synchronisers on both asynchronous pins.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
      end
   end

   assign w_clk_s = r_clk_sync[1];
   assign w_dat_s = r_dat_sync[1];

   // ------------------------------------------------------------------
   // ps2_clk deglitch. The counter runs while the synchronised pin
   // disagrees with the filtered level, and clears as soon as they agree.
   // The level flips on the FILTER_LEN-th consecutive disagreeing sample.
   // On a 1->0 flip, r_fall pulses for one cycle and r_bit holds the data
   // pin sampled on that same cycle.
   // ------------------------------------------------------------------
   logic          r_filt;
   logic [FW-1:0] r_fcnt;
   logic          r_fall;
   logic          r_bit;

   // Filtered clock level, fall pulse and data sample.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_filt <= 1'b1;
         r_fcnt <= '0;
         r_fall <= 1'b0;
         r_bit  <= 1'b1;
      end else begin
         r_fall <= 1'b0;
         if (w_clk_s == r_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= w_clk_s;
            r_fcnt <= '0;
            if (!w_clk_s) begin
               r_fall <= 1'b1;
               r_bit  <= w_dat_s;
            end
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM and its datapath.
   // ------------------------------------------------------------------
   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_shift;
   logic [2:0]    r_bcnt;
   logic          r_par;
   logic [TW-1:0] r_tcnt;
   logic          w_tmo;
   logic          w_par_ok;
   logic          w_err;
   logic          w_done;

   assign w_tmo    = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
   // Odd parity: the 8 data bits and the parity bit together hold an odd number of ones.
   assign w_par_ok = ^{r_shift, r_par};

   // State register.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic. A fall takes priority over a coincident timeout.
   // A fall always restarts the timeout anyway.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (r_fall && !r_bit) w_next = S_DATA;
         end
         S_DATA: begin
            if (r_fall) begin
               if (r_bcnt == 3'd7) w_next = S_PARITY;
            end else if (w_tmo) begin
               w_next = S_IDLE;
            end
         end
         S_PARITY: begin
            if (r_fall)     w_next = S_STOP;
            else if (w_tmo) w_next = S_IDLE;
         end
         S_STOP: begin
            if (r_fall || w_tmo) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: framing/timeout error and good-byte completion.
   always_comb begin
      w_err  = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_fall && r_bit) w_err = 1'b1;
         end
         S_DATA, S_PARITY: begin
            if (!r_fall && w_tmo) w_err = 1'b1;
         end
         S_STOP: begin
            if (r_fall) begin
               if (r_bit && w_par_ok) w_done = 1'b1;
               else                   w_err  = 1'b1;
            end else if (w_tmo) begin
               w_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shift register (LSB first), bit counter, parity capture, frame timeout counter.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_shift <= '0;
         r_bcnt  <= '0;
         r_par   <= 1'b0;
         r_tcnt  <= '0;
      end else begin
         if (r_state == S_IDLE || r_fall) r_tcnt <= '0;
         else if (!w_tmo)                 r_tcnt <= r_tcnt + 1'b1;

         if (r_fall) begin
            unique case (r_state)
               S_IDLE:   r_bcnt <= '0;
               S_DATA: begin
                  r_shift <= {r_bit, r_shift[7:1]};
                  r_bcnt  <= r_bcnt + 1'b1;
               end
               S_PARITY: r_par <= r_bit;
               S_STOP:   ;
               default:  ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Byte handling, one cycle after the stop bit is accepted.
   // ------------------------------------------------------------------
   logic       r_byte_vld;
   logic [7:0] r_byte;
   logic [7:0] w_ascii;
   logic [7:0] r_held;
   logic       r_brk;
   logic       r_ext;

   // Set-2 scancode to ASCII. Zero marks an unmapped code.
   function automatic logic [7:0] key_ascii(input logic [7:0] code);
      unique case (code)
         8'h1D:   key_ascii = 8'h77;  // w
         8'h1B:   key_ascii = 8'h73;  // s
         8'h1C:   key_ascii = 8'h61;  // a
         8'h23:   key_ascii = 8'h64;  // d
         8'h2D:   key_ascii = 8'h72;  // r
         8'h29:   key_ascii = 8'h20;  // space
         default: key_ascii = 8'h00;
      endcase
   endfunction

   assign w_ascii = key_ascii(r_byte);

   // Register each completed byte so that decode has a full cycle.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_byte_vld <= 1'b0;
         r_byte     <= '0;
      end else begin
         r_byte_vld <= w_done;
         if (w_done) r_byte <= r_shift;
      end
   end

   // Prefix flags, held-key tracking, ASCII output and the one-cycle strobes.
   // r_held stores the ASCII of the key that is down; 0 means no key is down.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         data      <= '0;
         display   <= 1'b0;
         key_held  <= 1'b0;
         frame_err <= 1'b0;
         r_held    <= '0;
         r_brk     <= 1'b0;
         r_ext     <= 1'b0;
      end else begin
         display   <= 1'b0;
         frame_err <= w_err;
         if (r_byte_vld) begin
            if (r_byte == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if (!r_ext && w_ascii != 8'h00) begin
                  if (r_brk) begin
                     // Only releasing the held key is reported.
                     if (w_ascii == r_held) begin
                        data     <= 8'h00;
                        display  <= 1'b1;
                        key_held <= 1'b0;
                        r_held   <= 8'h00;
                     end
                  end else if (w_ascii != r_held) begin
                     // A new key takes over. A typematic repeat of the held key is silent.
                     r_held   <= w_ascii;
                     data     <= w_ascii;
                     display  <= 1'b1;
                     key_held <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder. PS/2 frames are sent bit by bit
// on the pins. The expected outputs come from a scancode-level model of key
// state (held key, break/extended prefixes), with directed cases first and a
// random frame stream after them.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 300;
   localparam int H          = 20;   // clk cycles per PS/2 clock half-period

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data;
   logic       display;
   logic       key_held;
   logic       frame_err;

   always #5 clk = ~clk;

   ps2_key_decoder #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data     (data),
      .display  (display),
      .key_held (key_held),
      .frame_err(frame_err)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int obs_disp = 0;
   int obs_err  = 0;
   int viol     = 0;
   int fall_cyc = 0;
   int last_disp_cyc = 0;
   bit prev_d   = 0;
   bit prev_e   = 0;

   // reference model state
   logic [7:0] keymap [256];
   logic [7:0] m_held = 8'h00;
   logic [7:0] m_data = 8'h00;
   bit         m_brk  = 0;
   bit         m_ext  = 0;
   int         e_disp = 0;
   int         e_err  = 0;

   always @(posedge clk) cyc++;

   // observe strobes and flag any strobe wider than one cycle
   always @(negedge clk) begin
      if (display) begin
         obs_disp++;
         last_disp_cyc = cyc;
      end
      if (frame_err) obs_err++;
      if (display && prev_d) viol++;
      if (frame_err && prev_e) viol++;
      prev_d = display;
      prev_e = frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   // drive the first n bits of a frame (start first) onto the pins
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) fall_cyc = cyc;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
      @(negedge clk);
      ps2_data = 1'b1;
   endtask

   // scancode-level key behaviour
   task automatic model_byte(input logic [7:0] b, input bit good);
      logic [7:0] a;
      if (!good) begin
         e_err++;
         return;
      end
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         a = keymap[b];
         if (!m_ext && a != 8'h00) begin
            if (m_brk) begin
               if (a == m_held) begin
                  m_held = 8'h00; m_data = 8'h00; e_disp++;
               end
            end else if (a != m_held) begin
               m_held = a; m_data = a; e_disp++;
            end
         end
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
      send_bits(mk_frame(b, bad_par, bad_stop), 11);
      model_byte(b, !bad_par && !bad_stop);
   endtask

   task automatic check_pt(input string tag);
      repeat (20) @(negedge clk);
      #1;
      chk({tag, ".disp"},  obs_disp, e_disp);
      chk({tag, ".data"},  {24'h0, data}, {24'h0, m_data});
      chk({tag, ".held"},  {31'h0, key_held}, {31'h0, (m_held != 8'h00)});
      chk({tag, ".ferr"},  obs_err, e_err);
      obs_disp = 0; obs_err = 0; e_disp = 0; e_err = 0;
   endtask

   task automatic model_reset();
      m_held = 8'h00; m_data = 8'h00; m_brk = 0; m_ext = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pool [6];
      int r, k;
      logic [7:0] b;

      for (int i = 0; i < 256; i++) keymap[i] = 8'h00;
      keymap[8'h1D] = 8'h77; keymap[8'h1B] = 8'h73; keymap[8'h1C] = 8'h61;
      keymap[8'h23] = 8'h64; keymap[8'h2D] = 8'h72; keymap[8'h29] = 8'h20;
      pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h1C;
      pool[3] = 8'h23; pool[4] = 8'h2D; pool[5] = 8'h29;

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.data",  {24'h0, data}, 32'h0);
      chk("rst.disp",  {31'h0, display}, 32'h0);
      chk("rst.held",  {31'h0, key_held}, 32'h0);
      chk("rst.ferr",  {31'h0, frame_err}, 32'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      obs_disp = 0; obs_err = 0;

      // make of w, with strobe latency: 2 sync stages + filter + 2 decode cycles
      frame(8'h1D);
      chk("t1.latency", last_disp_cyc - fall_cyc, 2 + FILTER_LEN + 2);
      check_pt("t1");

      // typematic repeats are silent, then release
      frame(8'h1D); check_pt("t2.rep1");
      frame(8'h1D); check_pt("t2.rep2");
      frame(8'hF0); frame(8'h1D); check_pt("t2.brk");

      // key rollover: only the held key's release is reported
      frame(8'h1C); check_pt("t3.a");
      frame(8'h23); check_pt("t3.d");
      frame(8'hF0); frame(8'h1C); check_pt("t3.brk_a");
      frame(8'hF0); frame(8'h23); check_pt("t3.brk_d");

      // parity error then recovery
      frame(8'h1B, 1, 0); check_pt("t4.badpar");
      frame(8'h1B); check_pt("t4.s");
      frame(8'hF0); frame(8'h1B); check_pt("t4.brk_s");

      // bad stop bit
      frame(8'h2D, 0, 1); check_pt("t4.badstop");

      // mid-frame timeout then recovery
      send_bits(mk_frame(8'h23, 0, 0), 5);
      repeat (TIMEOUT + 50) @(negedge clk);
      e_err++;
      check_pt("t5.tmo");
      frame(8'h23); check_pt("t5.d");
      frame(8'hF0); frame(8'h23); check_pt("t5.brk_d");

      // short glitches on ps2_clk are filtered out
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ps2_data = 1'($urandom_range(0, 1));
         ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (12) @(negedge clk);
      end
      ps2_data = 1'b1;
      check_pt("t6.glitch");

      // extended codes are ignored, even when the code is otherwise mapped
      frame(8'hE0); frame(8'h75); check_pt("t6.ext_up");
      frame(8'hE0); frame(8'h1D); check_pt("t6.ext_w");

      // a fall while idle with data high is a start-bit error
      send_bits(11'h001, 1);
      e_err++;
      check_pt("t6.badstart");

      // reset in the middle of a frame while a key is held
      frame(8'h1C); check_pt("t6.pre_rst");
      send_bits(mk_frame(8'h29, 0, 0), 4);
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6.rst.data", {24'h0, data}, 32'h0);
      chk("t6.rst.held", {31'h0, key_held}, 32'h0);
      chk("t6.rst.disp", {31'h0, display}, 32'h0);
      chk("t6.rst.ferr", {31'h0, frame_err}, 32'h0);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      obs_disp = 0; obs_err = 0;
      frame(8'h23); check_pt("t6.post_rst");

      // random frame stream
      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(0, 99);
         k = $urandom_range(0, 11);
         if (k < 6)       b = pool[k];
         else if (k < 9)  b = 8'hF0;
         else if (k == 9) b = 8'hE0;
         else             b = 8'($urandom_range(0, 255));
         if (r < 8)       frame(b, 1, 0);
         else if (r < 12) frame(b, 0, 1);
         else             frame(b);
         check_pt("rnd");
      end

      chk("pulse_width", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
